duzias_dispenser: RTL
=====================

Name: duzias_dispenser

Overview:
- Reverse of the dozen-packing counter chain: a stock of full dozens is loaded as two BCD digits, then released one item per request.
- A dozen is opened on demand, and its items are handed out with a down-counter.
- The BCD dozen count borrows downward until the stock is exhausted.
- Sits on the output side of the egg-handling datapath and feeds the display with the remaining dozens (units/tens) and the items left in the open dozen.

Parameters:
- ITEMS_PER_GROUP, 12: items per dozen. Legal range 2..15, fits 4 bits.
- MAX_DIGIT, 9: highest legal BCD digit value, used for load validation.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- load  in  1  load new stock from dezenas_in/unidades_in
- dezenas_in  in  4  BCD tens digit of dozens to load
- unidades_in  in  4  BCD units digit of dozens to load
- item_req  in  1  request one item; sampled every rising edge
- item_valid  out  1  one-cycle pulse: one item released
- item_pos  out  4  items still left in the open dozen (0 when none open)
- unidades_duzias  out  4  BCD units of unopened dozens remaining
- dezenas_duzias  out  4  BCD tens of unopened dozens remaining
- busy  out  1  stock or an open dozen remains
- empty  out  1  equals ~busy
- err  out  1  sticky error flag

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- All outputs are registered.
- Reset values:
  - state IDLE
  - item_valid=0, item_pos=0, unidades_duzias=0, dezenas_duzias=0
  - busy=0, empty=1, err=0
- States:
  - IDLE: no stock, item_pos=0.
  - LOADED: dozens>0, no dozen open, item_pos=0.
  - OPEN: a dozen is open, item_pos in 1..ITEMS_PER_GROUP-1.
- load (highest priority, any state, evaluated at the clock edge):
  - Either digit > MAX_DIGIT: err<=1, dozens<=00, item_pos<=0, state IDLE.
  - Valid and 00: err<=0, state IDLE, outputs cleared.
  - Valid and nonzero: err<=0, dozens<=digits, item_pos<=0, state LOADED.
  - An open dozen is discarded.
  - item_req in the same cycle is ignored; item_valid=0.
- item_req in LOADED (no load):
  - item_valid<=1.
  - Dozens decrement in BCD: units 0 becomes 9 and tens decrements; otherwise units-1.
  - item_pos<=ITEMS_PER_GROUP-1.
  - state OPEN.
- item_req in OPEN, item_pos>1: item_valid<=1, item_pos<=item_pos-1.
- item_req in OPEN, item_pos==1:
  - item_valid<=1, item_pos<=0.
  - Next state LOADED if dozens!=00, else IDLE.
- item_req in IDLE: no item. err behaviour is per the optional feature.
- Latency: item_valid is high in the cycle after the edge that sampled item_req. Back-to-back requests give one item per cycle with no bubbles, including across dozen boundaries.
- item_valid is low in every cycle without an accepted request.
- busy = (state != IDLE). Both busy and empty update with the same edge as the state change.
- Total items remaining = 12*dozens + item_pos. Each load yields exactly 12*N item_valid pulses.
- BCD outputs never leave 0..9. Dozens never underflow below 00.
- Reset asserted mid-operation clears everything immediately, without waiting for clk.

Optional Feature:
- Macro UNDERFLOW_ERR_EN.
  - Defined: item_req while IDLE (no load that cycle) sets err<=1 (sticky). err clears only on reset or a valid load.
  - Undefined: item_req in IDLE is silently ignored; err reflects only invalid BCD loads.

Test Plan:
- Reset while OPEN with item_pos=7, dozens=03 -> outputs immediately 0, empty=1, err=0; item_req afterward gives no item_valid.
- Load 01, then 13 consecutive item_req cycles:
  - 12 item_valid pulses.
  - item_pos sequence 11,10,...,0; dozens 00 after the first pulse.
  - empty=1 after the 12th pulse; 13th request gives no pulse.
- Load 10, one item_req -> dezenas_duzias=0, unidades_duzias=9 (borrow), item_pos=11, state OPEN.
- Load tens=3, units=4'hA -> err=1, empty=1, dozens 00; then load 02 -> err=0, 24 pulses available.
- In OPEN with item_pos=5, assert load=02 together with item_req -> no item_valid, item_pos=0, dozens=02, state LOADED.
- With UNDERFLOW_ERR_EN: from reset, item_req -> err=1, item_valid=0; without the macro -> err stays 0.

Source files
------------

// File: rtl/duzias_dispenser_if.sv
// Dispenser handshake bundle: stock load and item requests in, item pulses and display counts out.
// Latency: none (wiring only).
// Backpressure: none; the requester paces itself on item_valid/empty.
interface duzias_dispenser_if;
   logic       load;
   logic [3:0] dezenas_in;
   logic [3:0] unidades_in;
   logic       item_req;
   logic       item_valid;
   logic [3:0] item_pos;
   logic [3:0] unidades_duzias;
   logic [3:0] dezenas_duzias;
   logic       busy;
   logic       empty;
   logic       err;

   modport master (
      output load, dezenas_in, unidades_in, item_req,
      input  item_valid, item_pos, unidades_duzias, dezenas_duzias, busy, empty, err
   );

   modport slave (
      input  load, dezenas_in, unidades_in, item_req,
      output item_valid, item_pos, unidades_duzias, dezenas_duzias, busy, empty, err
   );
endinterface

// File: rtl/duzias_dispenser.sv
// Releases BCD-counted dozens one item per request; UNDERFLOW_ERR_EN flags requests on empty stock.
// Latency: item_valid one cycle after the sampling edge, back-to-back at one item per cycle.
// Backpressure: none; requests with no stock are dropped (or flagged when the macro is defined).
module duzias_dispenser #(
   parameter int ITEMS_PER_GROUP = 12,
   parameter int MAX_DIGIT       = 9
) (
   input logic                clk,
   input logic                reset,
   duzias_dispenser_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      OPEN   = 2'd2
   } state_t;

   localparam logic [3:0] LAST_POS  = 4'(ITEMS_PER_GROUP - 1);
   localparam logic [3:0] MAX_BCD   = 4'(MAX_DIGIT);

   state_t     state_q, state_d;
   logic [3:0] pos_q, pos_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] units_q, units_d;
   logic       valid_q, valid_d;
   logic       err_q, err_d;
   logic       busy_q, busy_d;
   logic       empty_q;

   logic load_bad;
   logic load_zero;
   logic stock_left;

   assign load_bad   = (bus.dezenas_in > MAX_BCD) || (bus.unidades_in > MAX_BCD);
   assign load_zero  = (bus.dezenas_in == 4'd0) && (bus.unidades_in == 4'd0);
   assign stock_left = (tens_q != 4'd0) || (units_q != 4'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pos_q   <= 4'd0;
         tens_q  <= 4'd0;
         units_q <= 4'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         tens_q  <= tens_d;
         units_q <= units_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         empty_q <= ~busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      tens_d  = tens_q;
      units_d = units_q;
      valid_d = 1'b0;
      err_d   = err_q;

      // A load always wins and throws away any dozen that is currently open.
      if (bus.load) begin
         pos_d = 4'd0;
         if (load_bad) begin
            err_d   = 1'b1;
            tens_d  = 4'd0;
            units_d = 4'd0;
            state_d = IDLE;
         end else begin
            err_d   = 1'b0;
            tens_d  = bus.dezenas_in;
            units_d = bus.unidades_in;
            state_d = load_zero ? IDLE : LOADED;
         end
      end else if (bus.item_req) begin
         unique case (state_q)
            LOADED: begin
               valid_d = 1'b1;
               pos_d   = LAST_POS;
               state_d = OPEN;
               if (units_q == 4'd0) begin
                  units_d = 4'd9;
                  tens_d  = tens_q - 4'd1;
               end else begin
                  units_d = units_q - 4'd1;
               end
            end
            OPEN: begin
               valid_d = 1'b1;
               if (pos_q > 4'd1) begin
                  pos_d = pos_q - 4'd1;
               end else begin
                  pos_d   = 4'd0;
                  state_d = stock_left ? LOADED : IDLE;
               end
            end
            default: begin
`ifdef UNDERFLOW_ERR_EN
               err_d = 1'b1;
`endif
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   assign bus.item_valid      = valid_q;
   assign bus.item_pos        = pos_q;
   assign bus.unidades_duzias = units_q;
   assign bus.dezenas_duzias  = tens_q;
   assign bus.busy            = busy_q;
   assign bus.empty           = empty_q;
   assign bus.err             = err_q;

endmodule
